// File: rtl/mc_pkg.sv
// Shared encodings for the mc_controller_v2 multicycle RV32I control unit.
package mc_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_BRANCH = 7'b1100011,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_JALR, S_JALRWB,
        S_LUI, S_AUIPC, S_BRANCH, S_TRAP
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000, ALU_SUB  = 4'b0001, ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011, ALU_XOR  = 4'b0100, ALU_SLT  = 4'b0101,
        ALU_SLL  = 4'b0110, ALU_SRL  = 4'b0111, ALU_SRA  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10, SRCA_ZERO = 2'b11
    } srca_e;

    typedef enum logic [1:0] {
        SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10
    } srcb_e;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10
    } res_src_e;

    typedef enum logic [1:0] {
        ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10
    } aluop_e;

    // Branch condition from funct3 and the ALU compare flags; 010/011 never reach here.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                          input logic lt, input logic ltu);
        logic taken;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's ALU operation class and instruction fields to alucontrol.
module mc_aludec
    import mc_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       op5_i,
    output logic [3:0] alucontrol_o
);

    // Subtract only for R-type (op[5]=1) with funct7b5; I-type add ignores imm bit 30.
    always_comb begin
        alucontrol_o = ALU_ADD;
        case (aluop_i)
            ALUOP_ADD: alucontrol_o = ALU_ADD;
            ALUOP_SUB: alucontrol_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    3'b000:  alucontrol_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b001:  alucontrol_o = ALU_SLL;
                    3'b010:  alucontrol_o = ALU_SLT;
                    3'b011:  alucontrol_o = ALU_SLTU;
                    3'b100:  alucontrol_o = ALU_XOR;
                    3'b101:  alucontrol_o = funct7b5_i ? ALU_SRA : ALU_SRL;
                    3'b110:  alucontrol_o = ALU_OR;
                    3'b111:  alucontrol_o = ALU_AND;
                    default: alucontrol_o = ALU_ADD;
                endcase
            end
            default: alucontrol_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller_v2.sv
// Multicycle RV32I control FSM with memory watchdog and sticky traps.
// Define INSTRET_COUNTER_EN to build the retired-instruction counter.
module mc_controller_v2
    import mc_pkg::*;
#(
    parameter int WAIT_W    = 4,
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 zero,
    input  logic                 lt,
    input  logic                 ltu,
    input  logic                 mem_ready,
    output logic [2:0]           immsrc,
    output logic [1:0]           alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           resultsrc,
    output logic                 adrsrc,
    output logic [3:0]           alucontrol,
    output logic                 irwrite,
    output logic                 pcwrite,
    output logic                 regwrite,
    output logic                 memwrite,
    output logic                 memreq,
    output logic                 illegal,
    output logic                 bus_err,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((2 ** WAIT_W) - 2);

    state_e            state_q, state_d, fsm_next_s;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              illegal_q, illegal_d, bus_err_q, bus_err_d;
    logic              timeout_s;
    logic [1:0]        aluop_s;

    mc_aludec u_aludec (
        .aluop_i      (aluop_s),
        .funct3_i     (funct3),
        .funct7b5_i   (funct7b5),
        .op5_i        (op[5]),
        .alucontrol_o (alucontrol)
    );

    // Immediate format decode, independent of state.
    always_comb begin
        immsrc = IMM_I;
        case (op)
            OPC_STORE:           immsrc = IMM_S;
            OPC_BRANCH:          immsrc = IMM_B;
            OPC_JAL:             immsrc = IMM_J;
            OPC_LUI, OPC_AUIPC:  immsrc = IMM_U;
            default:             immsrc = IMM_I;
        endcase
    end

    // Per-state datapath controls and nominal next state.
    always_comb begin
        fsm_next_s = state_q;
        aluop_s    = ALUOP_ADD;
        alusrca    = SRCA_PC;
        alusrcb    = SRCB_RS2;
        resultsrc  = RES_ALUOUT;
        adrsrc     = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        memreq     = 1'b0;
        case (state_q)
            S_FETCH: begin
                memreq    = 1'b1;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALURESULT;
                if (mem_ready) begin
                    irwrite    = 1'b1;
                    pcwrite    = 1'b1;
                    fsm_next_s = S_DECODE;
                end else begin
                    fsm_next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
                case (op)
                    OPC_LOAD, OPC_STORE: fsm_next_s = S_MEMADR;
                    OPC_OP:              fsm_next_s = S_EXECR;
                    OPC_OP_IMM:          fsm_next_s = S_EXECI;
                    OPC_JAL:             fsm_next_s = S_JAL;
                    OPC_JALR:            fsm_next_s = S_JALR;
                    OPC_LUI:             fsm_next_s = S_LUI;
                    OPC_AUIPC:           fsm_next_s = S_AUIPC;
                    OPC_BRANCH: begin
                        if (funct3[2:1] == 2'b01) fsm_next_s = S_TRAP;
                        else                      fsm_next_s = S_BRANCH;
                    end
                    default:             fsm_next_s = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alusrca    = SRCA_RS1;
                alusrcb    = SRCB_IMM;
                fsm_next_s = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                memreq     = 1'b1;
                adrsrc     = 1'b1;
                fsm_next_s = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                resultsrc  = RES_DATA;
                regwrite   = 1'b1;
                fsm_next_s = S_FETCH;
            end
            S_MEMWRITE: begin
                memreq     = 1'b1;
                memwrite   = 1'b1;
                adrsrc     = 1'b1;
                fsm_next_s = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alusrca    = SRCA_RS1;
                aluop_s    = ALUOP_FUNCT;
                fsm_next_s = S_ALUWB;
            end
            S_EXECI: begin
                alusrca    = SRCA_RS1;
                alusrcb    = SRCB_IMM;
                aluop_s    = ALUOP_FUNCT;
                fsm_next_s = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite   = 1'b1;
                fsm_next_s = S_FETCH;
            end
            S_JAL: begin
                alusrca    = SRCA_OLDPC;
                alusrcb    = SRCB_FOUR;
                pcwrite    = 1'b1;
                fsm_next_s = S_ALUWB;
            end
            S_JALR: begin
                alusrca    = SRCA_RS1;
                alusrcb    = SRCB_IMM;
                resultsrc  = RES_ALURESULT;
                pcwrite    = 1'b1;
                fsm_next_s = S_JALRWB;
            end
            S_JALRWB: begin
                alusrca    = SRCA_OLDPC;
                alusrcb    = SRCB_FOUR;
                resultsrc  = RES_ALURESULT;
                regwrite   = 1'b1;
                fsm_next_s = S_FETCH;
            end
            S_LUI: begin
                alusrca    = SRCA_ZERO;
                alusrcb    = SRCB_IMM;
                fsm_next_s = S_ALUWB;
            end
            S_AUIPC: begin
                alusrca    = SRCA_OLDPC;
                alusrcb    = SRCB_IMM;
                fsm_next_s = S_ALUWB;
            end
            S_BRANCH: begin
                alusrca    = SRCA_RS1;
                aluop_s    = ALUOP_SUB;
                pcwrite    = branch_taken(funct3, zero, lt, ltu);
                fsm_next_s = S_FETCH;
            end
            S_TRAP:  fsm_next_s = S_TRAP;
            default: fsm_next_s = S_TRAP;
        endcase
    end

    // Watchdog override and sticky trap flags; the counter restarts on any state change.
    always_comb begin
        timeout_s = memreq && !mem_ready && (wait_cnt_q == WAIT_LAST);
        if (timeout_s) state_d = S_TRAP;
        else           state_d = fsm_next_s;
        if (mem_ready || !memreq || (state_d != state_q)) wait_cnt_d = '0;
        else                                             wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        illegal_d = illegal_q | ((state_q == S_DECODE) && (state_d == S_TRAP));
        bus_err_d = bus_err_q | timeout_s;
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;

`ifdef INSTRET_COUNTER_EN
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic                 retire_s;

    // An instruction retires when its final state hands back to FETCH.
    always_comb begin
        retire_s = (state_d == S_FETCH) &&
                   (state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_JALRWB, S_BRANCH});
        if (retire_s) instret_d = instret_q + INSTRET_W'(1);
        else          instret_d = instret_q;
    end

    // Retired-instruction counter register.
    always_ff @(posedge clk) begin
        if (!reset_n) instret_q <= '0;
        else          instret_q <= instret_d;
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_mc_controller_v2.sv
// Scoreboard bench for mc_controller_v2: per-cycle expected control vectors are queued, then replayed.
module tb_mc_controller_v2;

    logic        clk = 1'b0;
    logic        reset_n, funct7b5, zero, lt, ltu, mem_ready;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [2:0]  immsrc;
    logic [1:0]  alusrca, alusrcb, resultsrc;
    logic        adrsrc, irwrite, pcwrite, regwrite, memwrite, memreq, illegal, bus_err;
    logic [3:0]  alucontrol;
    logic [31:0] instret;
    logic [20:0] obs_v;

    typedef struct {
        logic [127:0] tag;
        logic         mr;
        logic [20:0]  v;
    } exp_t;

    exp_t        sb_q[$];
    int          total_cnt = 0;
    int          bad_cnt = 0;
    logic [2:0]  imm_exp;
    logic        ill_exp, be_exp;
    logic [31:0] instret_exp;

    mc_controller_v2 #(.WAIT_W(4), .INSTRET_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .immsrc(immsrc), .alusrca(alusrca), .alusrcb(alusrcb), .resultsrc(resultsrc),
        .adrsrc(adrsrc), .alucontrol(alucontrol), .irwrite(irwrite), .pcwrite(pcwrite),
        .regwrite(regwrite), .memwrite(memwrite), .memreq(memreq), .illegal(illegal),
        .bus_err(bus_err), .instret(instret)
    );

    always #5 clk = ~clk;

    assign obs_v = {immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
                    irwrite, pcwrite, regwrite, memwrite, memreq, illegal, bus_err};

    task automatic check_val(input logic [127:0] tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %0s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0100011:             return 3'b001;
            7'b1100011:             return 3'b010;
            7'b1101111:             return 3'b011;
            7'b0110111, 7'b0010111: return 3'b100;
            default:                return 3'b000;
        endcase
    endfunction

    task automatic set_ir(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7; imm_exp = imm_of(o);
    endtask

    task automatic push(input logic [127:0] tag, input logic mr, input logic [1:0] a,
                        input logic [1:0] b, input logic [1:0] r, input logic adr,
                        input logic [3:0] alu, input logic ir, input logic pc,
                        input logic rw, input logic mw, input logic mq);
        exp_t e;
        e.tag = tag;
        e.mr  = mr;
        e.v   = {imm_exp, a, b, r, adr, alu, ir, pc, rw, mw, mq, ill_exp, be_exp};
        sb_q.push_back(e);
    endtask

    task automatic p_fetch(input logic mr);
        push("fetch", mr, 2'b00, 2'b10, 2'b10, 1'b0, 4'b0000, mr, mr, 1'b0, 1'b0, 1'b1);
    endtask
    task automatic p_decode();
        push("decode", 1'b1, 2'b01, 2'b01, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic p_aluwb();
        push("aluwb", 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask
    task automatic p_memadr();
        push("memadr", 1'b1, 2'b10, 2'b01, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic p_trap(input int n);
        for (int i = 0; i < n; i++)
            push("trap", 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Called at a falling edge; each entry drives mem_ready, compares, then moves one cycle on.
    task automatic run_sb();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            mem_ready = e.mr;
            #1;
            check_val(e.tag, {11'd0, obs_v}, {11'd0, e.v});
            @(negedge clk);
        end
    endtask

    task automatic retire();
`ifdef INSTRET_COUNTER_EN
        instret_exp = instret_exp + 32'd1;
`endif
        check_val("instret", instret, instret_exp);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        ill_exp = 1'b0; be_exp = 1'b0; instret_exp = 32'd0;
    endtask

    task automatic alu_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic [3:0] alu_exp);
        set_ir(o, f3, f7);
        p_fetch(1'b1);
        p_decode();
        push("exec", 1'b1, 2'b10, o[5] ? 2'b00 : 2'b01, 2'b00, 1'b0, alu_exp,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        p_aluwb();
        run_sb();
        retire();
    endtask

    task automatic branch(input logic [2:0] f3, input logic z, input logic l,
                          input logic lu, input logic taken);
        set_ir(7'b1100011, f3, 1'b0);
        zero = z; lt = l; ltu = lu;
        p_fetch(1'b1);
        p_decode();
        push("branch", 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 4'b0001, 1'b0, taken, 1'b0, 1'b0, 1'b0);
        run_sb();
        retire();
    endtask

    initial begin
        reset_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
        ill_exp = 1'b0; be_exp = 1'b0; instret_exp = 32'd0;
        set_ir(7'b0110011, 3'b000, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check_val("rst_instret", instret, 32'd0);

        // add with two fetch stalls first
        p_fetch(1'b0);
        p_fetch(1'b0);
        run_sb();
        alu_instr(7'b0110011, 3'b000, 1'b0, 4'b0000);
        alu_instr(7'b0110011, 3'b000, 1'b1, 4'b0001);
        alu_instr(7'b0110011, 3'b011, 1'b0, 4'b1001);
        alu_instr(7'b0110011, 3'b111, 1'b0, 4'b0010);
        alu_instr(7'b0010011, 3'b000, 1'b1, 4'b0000);
        alu_instr(7'b0010011, 3'b100, 1'b0, 4'b0100);
        alu_instr(7'b0010011, 3'b101, 1'b1, 4'b1000);
        alu_instr(7'b0010011, 3'b101, 1'b0, 4'b0111);
        alu_instr(7'b0010011, 3'b001, 1'b0, 4'b0110);

        // lw with three not-ready cycles in MEMREAD
        set_ir(7'b0000011, 3'b010, 1'b0);
        p_fetch(1'b1); p_decode(); p_memadr();
        for (int i = 0; i < 4; i++)
            push("memread", i == 3, 2'b00, 2'b00, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        push("memwb", 1'b1, 2'b00, 2'b00, 2'b01, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_sb();
        retire();

        // sw completing exactly on the watchdog limit cycle
        set_ir(7'b0100011, 3'b010, 1'b0);
        p_fetch(1'b1); p_decode(); p_memadr();
        for (int i = 0; i < 15; i++)
            push("memwrite", i == 14, 2'b00, 2'b00, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        run_sb();
        retire();

        branch(3'b101, 1'b0, 1'b0, 1'b0, 1'b1);
        branch(3'b101, 1'b0, 1'b1, 1'b0, 1'b0);
        branch(3'b110, 1'b0, 1'b0, 1'b1, 1'b1);
        branch(3'b111, 1'b0, 1'b0, 1'b1, 1'b0);
        branch(3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
        branch(3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        branch(3'b100, 1'b0, 1'b1, 1'b0, 1'b1);

        // jalr
        set_ir(7'b1100111, 3'b000, 1'b0);
        p_fetch(1'b1); p_decode();
        push("jalr", 1'b1, 2'b10, 2'b01, 2'b10, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push("jalrwb", 1'b1, 2'b01, 2'b10, 2'b10, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_sb();
        retire();

        // jal, lui, auipc
        set_ir(7'b1101111, 3'b000, 1'b0);
        p_fetch(1'b1); p_decode();
        push("jal", 1'b1, 2'b01, 2'b10, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        p_aluwb();
        run_sb();
        retire();
        set_ir(7'b0110111, 3'b000, 1'b0);
        p_fetch(1'b1); p_decode();
        push("lui", 1'b1, 2'b11, 2'b01, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        p_aluwb();
        run_sb();
        retire();
        set_ir(7'b0010111, 3'b000, 1'b0);
        p_fetch(1'b1); p_decode();
        push("auipc", 1'b1, 2'b01, 2'b01, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        p_aluwb();
        run_sb();
        retire();

        // illegal opcode traps and holds for ten cycles
        set_ir(7'b0001111, 3'b000, 1'b0);
        p_fetch(1'b1); p_decode();
        ill_exp = 1'b1;
        p_trap(10);
        run_sb();
        check_val("trap_instret", instret, instret_exp);
        do_reset();
        check_val("rst2_instret", instret, 32'd0);
        alu_instr(7'b0110011, 3'b000, 1'b0, 4'b0000);

        // reserved branch funct3 traps
        set_ir(7'b1100011, 3'b010, 1'b0);
        p_fetch(1'b1); p_decode();
        ill_exp = 1'b1;
        p_trap(3);
        run_sb();
        do_reset();

        // sw with memory never ready: watchdog trap after fifteen cycles
        set_ir(7'b0100011, 3'b010, 1'b0);
        p_fetch(1'b1); p_decode(); p_memadr();
        for (int i = 0; i < 15; i++)
            push("memwr_to", 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        be_exp = 1'b1;
        p_trap(4);
        run_sb();
        do_reset();
        set_ir(7'b0010011, 3'b000, 1'b0);
        p_fetch(1'b0);
        run_sb();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/mc_controller_v2.md
Name: mc_controller_v2

Overview:
- Next-generation multicycle RV32I control unit; drives the shared multicycle datapath (PC, IR, OldPC, ALUOut, Data registers, unified memory).
- Adds over the first generation: memory ready/wait handshake with timeout, full branch set, jalr/lui/auipc, xor/sltu/shift decode, illegal-instruction trap, optional retired-instruction counter.

Parameters:
- WAIT_W, 4, width of memory-wait watchdog; timeout after 2**WAIT_W-1 consecutive not-ready cycles
- INSTRET_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- zero  in  1  ALU result == 0
- lt  in  1  ALU signed less-than flag from rs1-rs2
- ltu  in  1  ALU unsigned less-than flag
- mem_ready  in  1  memory completes access this cycle
- immsrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- alusrca  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
- alusrcb  out  2  00 rs2, 01 imm, 10 const 4
- resultsrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- adrsrc  out  1  0 PC, 1 Result
- alucontrol  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra, 1001 sltu
- irwrite, pcwrite, regwrite, memwrite, memreq  out  1 each
- illegal  out  1  sticky illegal-opcode trap
- bus_err  out  1  sticky memory timeout trap
- instret  out  INSTRET_W  retired-instruction count

Behaviour:
- Reset (reset_n=0 at posedge): state=FETCH, wait counter=0, instret=0, illegal=0, bus_err=0. Reset overrides any state, including traps and mid-wait.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, JALR, JALRWB, LUI, AUIPC, BRANCH, TRAP.
- FETCH:
  - Outputs: memreq=1, adrsrc=0, alusrca=00, alusrcb=10, add, resultsrc=10.
  - irwrite and pcwrite assert only when mem_ready=1; FETCH->DECODE on mem_ready, else stay.
- DECODE:
  - Outputs: alusrca=01, alusrcb=01, add.
  - Next state by opcode: 0000011/0100011->MEMADR; 0110011->EXECR; 0010011->EXECI; 1101111->JAL; 1100111->JALR; 0110111->LUI; 0010111->AUIPC; 1100011->BRANCH; anything else->TRAP.
  - BRANCH with funct3 010/011 also ->TRAP.
- MEMADR: alusrca=10, alusrcb=01, add; ->MEMREAD (load) or MEMWRITE (store).
- MEMREAD: memreq=1, adrsrc=1, resultsrc=00; ->MEMWB on mem_ready, else stay.
- MEMWB: resultsrc=01, regwrite=1; ->FETCH.
- MEMWRITE: memreq=1, memwrite=1, adrsrc=1; both held until mem_ready; ->FETCH on mem_ready.
- EXECR: alusrca=10, alusrcb=00, funct decode; ->ALUWB.
- EXECI: alusrca=10, alusrcb=01, funct decode; sub never selected; ->ALUWB.
- ALUWB: resultsrc=00, regwrite=1; ->FETCH.
- JAL: alusrca=01, alusrcb=10, add, resultsrc=00, pcwrite=1; ->ALUWB.
- JALR: alusrca=10, alusrcb=01, add, resultsrc=10, pcwrite=1; ->JALRWB.
- JALRWB: alusrca=01, alusrcb=10, add, resultsrc=10, regwrite=1; ->FETCH.
- LUI: alusrca=11, alusrcb=01, add; ->ALUWB. AUIPC: alusrca=01, alusrcb=01, add; ->ALUWB.
- BRANCH:
  - Outputs: alusrca=10, alusrcb=00, sub, resultsrc=00; ->FETCH.
  - pcwrite=taken, where taken by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
- TRAP: all write/req outputs 0; stays until reset. illegal=1 if entered from DECODE; bus_err=1 if entered on timeout.
- Watchdog:
  - Counts consecutive cycles with memreq=1 and mem_ready=0; clears when mem_ready=1 or the state changes.
  - On reaching 2**WAIT_W-1 with mem_ready still 0: ->TRAP next cycle.
  - mem_ready=1 on the limit cycle wins; no trap.
- immsrc: combinational from op; unknown opcodes give 000.
- Unlisted signals are 0 in every state.
- With mem_ready tied 1, cycle counts match the first-generation controller.

Optional Feature:
- INSTRET_COUNTER_EN defined: instret increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB, JALRWB or BRANCH. Wraps modulo 2**INSTRET_W. Not incremented in TRAP.
- Undefined: instret is constant 0 and no counter flops are built.

Decomposition:
- Package mc_pkg holds:
  - opcode enum (10 opcodes)
  - state enum
  - alucontrol, immsrc, alusrca/b and resultsrc encodings
- Sub-module mc_aludec: combinational aluop/funct3/funct7b5/op[5] -> 4-bit alucontrol.

Test Plan:
- add (op=0110011, f3=000, f7b5=0), mem_ready=1 -> FETCH, DECODE, EXECR (alucontrol=0000), ALUWB (regwrite=1); 4 cycles; instret 0->1.
- lw with mem_ready low 3 cycles in MEMREAD, WAIT_W=4 -> MEMREAD held 4 cycles, memreq=1 throughout, then MEMWB regwrite=1; no bus_err.
- sw with mem_ready never asserted, WAIT_W=2 -> memwrite held 3 cycles, then TRAP, bus_err=1, memwrite=0.
- bge (f3=101): lt=0 -> pcwrite=1 in BRANCH; lt=1 -> pcwrite=0; bltu (f3=110) with ltu=1 -> pcwrite=1.
- jalr -> JALR pcwrite=1 with resultsrc=10, then JALRWB regwrite=1 with alusrca=01, alusrcb=10.
- op=0001111 -> TRAP after DECODE, illegal=1, no writes for 10 cycles; reset_n=0 one cycle -> FETCH, illegal=0, memreq=1.
